soc_system_ocr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one port of the 1024x32 on-chip RAM between two Avalon-MM

---
 rtl/soc_system_ocr_arbiter.sv | 114 +++++++++++
 tb/tb_soc_system_ocr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_ocr_arbiter.sv
// rtl/soc_system_ocr_arbiter.sv - round-robin arbiter sharing one on-chip RAM port between two Avalon-MM masters
module soc_system_ocr_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    logic                    last_grant_q, last_grant_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] own_q, own_d;
    logic [DATA_W-1:0]       rdata0_q, rdata0_d;
    logic [DATA_W-1:0]       rdata1_q, rdata1_d;

    logic req0, req1, grant0, grant1, any_grant, win_write, grant_read;
    logic rdv0, rdv1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // On a tie the master that did not win last time gets the port.
    assign grant0    = ~reset & req0 & (~req1 | last_grant_q);
    assign grant1    = ~reset & req1 & (~req0 | ~last_grant_q);
    assign any_grant = grant0 | grant1;
    assign win_write = grant1 ? m1_write : (grant0 & m0_write);
    assign grant_read = any_grant & ~win_write;

    assign m0_waitrequest = reset | (req0 & ~grant0);
    assign m1_waitrequest = reset | (req1 & ~grant1);

    always_comb begin
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        if (grant1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
        end else if (grant0) begin
            ram_address    = m0_address;
            ram_byteenable = m0_byteenable;
            ram_writedata  = m0_writedata;
        end
    end

    assign ram_chipselect = any_grant;
    assign ram_write      = win_write;
    assign ram_clken      = 1'b1;

    // Last stage of the tracking pipe lines up with the RAM read data.
    assign rdv0 = ~reset & vld_q[READ_LATENCY-1] & ~own_q[READ_LATENCY-1];
    assign rdv1 = ~reset & vld_q[READ_LATENCY-1] &  own_q[READ_LATENCY-1];

    assign m0_readdatavalid = rdv0;
    assign m1_readdatavalid = rdv1;
    assign m0_readdata      = rdv0 ? ram_readdata : rdata0_q;
    assign m1_readdata      = rdv1 ? ram_readdata : rdata1_q;

    always_comb begin
        last_grant_d = any_grant ? grant1 : last_grant_q;
        vld_d        = '0;
        own_d        = '0;
        vld_d[0]     = grant_read;
        own_d[0]     = grant1;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
        rdata0_d = rdv0 ? ram_readdata : rdata0_q;
        rdata1_d = rdv1 ? ram_readdata : rdata1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            vld_q        <= '0;
            own_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            vld_q        <= vld_d;
            own_q        <= own_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_soc_system_ocr_arbiter.sv
// tb/tb_soc_system_ocr_arbiter.sv - scoreboard bench for soc_system_ocr_arbiter at READ_LATENCY 1 and 3
module tb_soc_system_ocr_arbiter;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;

    logic        m0_wait_a, m1_wait_a, m0_rdv_a, m1_rdv_a;
    logic [31:0] m0_rd_a, m1_rd_a;
    logic [9:0]  ram_addr_a;
    logic [3:0]  ram_be_a;
    logic        ram_cs_a, ram_wr_a, ram_clken_a;
    logic [31:0] ram_wd_a, ram_rd_a;

    logic        m0_wait_b, m1_wait_b, m0_rdv_b, m1_rdv_b;
    logic [31:0] m0_rd_b, m1_rd_b;
    logic [9:0]  ram_addr_b;
    logic [3:0]  ram_be_b;
    logic        ram_cs_b, ram_wr_b, ram_clken_b;
    logic [31:0] ram_wd_b, ram_rd_b;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [31:0] rp_a;
    logic [31:0] rp_b [0:2];

    exp_t q [4][$];
    int   cyc_cnt = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    soc_system_ocr_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_wait_a),
        .m0_readdata(m0_rd_a), .m0_readdatavalid(m0_rdv_a),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_wait_a),
        .m1_readdata(m1_rd_a), .m1_readdatavalid(m1_rdv_a),
        .ram_address(ram_addr_a), .ram_byteenable(ram_be_a), .ram_chipselect(ram_cs_a),
        .ram_write(ram_wr_a), .ram_writedata(ram_wd_a), .ram_clken(ram_clken_a),
        .ram_readdata(ram_rd_a)
    );

    soc_system_ocr_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_wait_b),
        .m0_readdata(m0_rd_b), .m0_readdatavalid(m0_rdv_b),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_wait_b),
        .m1_readdata(m1_rd_b), .m1_readdatavalid(m1_rdv_b),
        .ram_address(ram_addr_b), .ram_byteenable(ram_be_b), .ram_chipselect(ram_cs_b),
        .ram_write(ram_wr_b), .ram_writedata(ram_wd_b), .ram_clken(ram_clken_b),
        .ram_readdata(ram_rd_b)
    );

    // Behavioural RAMs: write with byte lanes, registered read of the given latency.
    always @(posedge clk) begin
        if (ram_cs_a && ram_wr_a) begin
            for (int j = 0; j < 4; j++)
                if (ram_be_a[j]) mem_a[ram_addr_a][8*j +: 8] <= ram_wd_a[8*j +: 8];
        end else if (ram_cs_a) begin
            rp_a <= mem_a[ram_addr_a];
        end
    end
    assign ram_rd_a = rp_a;

    always @(posedge clk) begin
        if (ram_cs_b && ram_wr_b) begin
            for (int j = 0; j < 4; j++)
                if (ram_be_b[j]) mem_b[ram_addr_b][8*j +: 8] <= ram_wd_b[8*j +: 8];
        end else if (ram_cs_b) begin
            rp_b[0] <= mem_b[ram_addr_b];
        end
        rp_b[1] <= rp_b[0];
        rp_b[2] <= rp_b[1];
    end
    assign ram_rd_b = rp_b[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc_cnt, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic rdv, input logic [31:0] data);
        exp_t e;
        if (rdv === 1'b1) begin
            if (q[k].size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdv stream=%0d cycle=%0d actual=%h required=none", k, cyc_cnt, data);
            end else begin
                e = q[k].pop_front();
                chk($sformatf("rdata_s%0d", k), data, e.d);
                chk($sformatf("rdv_cycle_s%0d", k), cyc_cnt, e.due);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, m0_rdv_a, m0_rd_a);
        mon(1, m1_rdv_a, m1_rd_a);
        mon(2, m0_rdv_b, m0_rd_b);
        mon(3, m1_rdv_b, m1_rd_b);
    end

    task automatic push(input int m, input logic [31:0] d);
        exp_t e;
        e.d = d;
        e.due = cyc_cnt + 1;
        q[m].push_back(e);
        e.due = cyc_cnt + 3;
        q[m+2].push_back(e);
    endtask

    // One bus cycle: m0 may only read; m1 may read and/or write.
    task automatic cyc(input logic r0, input logic [9:0] a0,
                       input logic r1, input logic w1, input logic [9:0] a1,
                       input logic [31:0] d1, input logic [3:0] be1,
                       input logic ew0, input logic ew1,
                       input logic p0, input logic [31:0] e0,
                       input logic p1, input logic [31:0] e1);
        @(posedge clk);
        #1;
        m0_read = r0; m0_write = 1'b0; m0_address = a0; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
        @(negedge clk);
        chk("wait0_a", {31'd0, m0_wait_a}, {31'd0, ew0});
        chk("wait1_a", {31'd0, m1_wait_a}, {31'd0, ew1});
        chk("wait0_b", {31'd0, m0_wait_b}, {31'd0, ew0});
        chk("wait1_b", {31'd0, m1_wait_b}, {31'd0, ew1});
        if (p0) push(0, e0);
        if (p1) push(1, e1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic reset_checks();
        chk("rst_wait0", {31'd0, m0_wait_a}, 32'd1);
        chk("rst_wait1", {31'd0, m1_wait_b}, 32'd1);
        chk("rst_cs", {31'd0, ram_cs_a | ram_cs_b}, 32'd0);
        chk("rst_wr", {31'd0, ram_wr_a | ram_wr_b}, 32'd0);
        chk("rst_rdv", {28'd0, m0_rdv_a, m1_rdv_a, m0_rdv_b, m1_rdv_b}, 32'd0);
        chk("rst_rd0", m0_rd_a, 32'd0);
        chk("rst_rd1", m1_rd_b, 32'd0);
        chk("rst_clken", {30'd0, ram_clken_a, ram_clken_b}, 32'd3);
    endtask

    initial begin
        reset = 1'b1;
        m0_read = 1'b1; m0_write = 1'b0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_read = 1'b1; m1_write = 1'b0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
        rp_a = '0;
        for (int i = 0; i < 3; i++) rp_b[i] = '0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'h1000_0000 + i;
            mem_b[i] = 32'h1000_0000 + i;
        end
        mem_a[10'h005] = 32'hDEADBEEF; mem_b[10'h005] = 32'hDEADBEEF;
        mem_a[10'h3FF] = 32'hFFFFFFFF; mem_b[10'h3FF] = 32'hFFFFFFFF;

        @(negedge clk);
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1;
        reset = 1'b0;
        m0_read = 1'b0; m1_read = 1'b0;

        // Continuous contention: m0 first, then alternating.
        for (int k = 0; k < 6; k++) begin
            logic odd;
            odd = (k % 2) == 1;
            cyc(1'b1, 10'h010, 1'b1, 1'b0, 10'h020, 32'h0, 4'hF,
                odd, ~odd, ~odd, 32'h1000_0010, odd, 32'h1000_0020);
        end

        cyc(1'b1, 10'h005, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        idle(4);
        chk("hold_rd0_a", m0_rd_a, 32'hDEADBEEF);
        chk("hold_rd0_b", m0_rd_b, 32'hDEADBEEF);

        // Partial write by m1, then immediate read by m0.
        cyc(1'b0, 10'h0, 1'b0, 1'b1, 10'h3FF, 32'h12345678, 4'b0011, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 10'h3FF, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF5678, 1'b0, 32'h0);

        for (int i = 0; i < 8; i++)
            cyc(1'b1, 10'(i), 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 1'b0,
                1'b1, (i == 5) ? 32'hDEADBEEF : 32'h1000_0000 + i, 1'b0, 32'h0);

        // Read and write together is a plain write.
        cyc(1'b0, 10'h0, 1'b1, 1'b1, 10'h001, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 10'h001, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0);
        idle(4);
        chk("hold_rd0_a2", m0_rd_a, 32'hA5A5A5A5);
        chk("hold_rd1_b", m1_rd_b, 32'h1000_0020);

        // Read in flight when reset hits: must never come back.
        cyc(1'b1, 10'h002, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m0_read = 1'b1; m1_read = 1'b1;
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1;
        reset = 1'b0;
        m0_read = 1'b0; m1_read = 1'b0;
        cyc(1'b1, 10'h003, 1'b1, 1'b0, 10'h004, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 32'h1000_0003, 1'b0, 32'h0);
        cyc(1'b0, 10'h0, 1'b1, 1'b0, 10'h004, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000_0004);
        idle(5);

        for (int k = 0; k < 4; k++)
            chk($sformatf("pending_s%0d", k), q[k].size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
